// File: rtl/nn_weight_loader_if.sv
// Byte-stream receive handshake plus weight-burst delivery bundle between a frame source and xor_nn.
interface nn_weight_loader_if #(
    parameter int BITS_PER_WORD = 8
);
    logic                     rx_valid;
    logic [BITS_PER_WORD-1:0] rx_data;
    logic                     rx_ready;
    logic                     weights_en;
    logic [BITS_PER_WORD-1:0] weights_data;
    logic                     load_done;
    logic                     load_error;
    logic                     busy;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, weights_en, weights_data, load_done, load_error, busy
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, weights_en, weights_data, load_done, load_error, busy
    );
endinterface

// File: rtl/nn_weight_loader.sv
// Buffers a sync/weights/checksum frame and replays the weights to xor_nn as one burst only if the sum checks.
// Burst starts 2 edges after the checksum byte; rx_ready is low in CHECK/REPLAY, downstream cannot stall.
module nn_weight_loader #(
    parameter int                       BITS_PER_WORD = 8,
    parameter int                       WEIGHT_COUNT  = 9,
    parameter logic [BITS_PER_WORD-1:0] SYNC_WORD     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    nn_weight_loader_if.slave bus
);
    localparam int             CW   = $clog2(WEIGHT_COUNT + 1);
    localparam logic [CW-1:0]  LAST = CW'(WEIGHT_COUNT);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECV   = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_REPLAY = 2'd3;

    logic [1:0]               state;
    logic [CW-1:0]            cnt;
    logic [BITS_PER_WORD-1:0] sum;
    logic [BITS_PER_WORD-1:0] wbuf [WEIGHT_COUNT];

    logic                     rx_ready;
    logic                     weights_en;
    logic [BITS_PER_WORD-1:0] weights_data;
    logic                     load_done;
    logic                     load_error;
    logic                     busy;
    logic                     accept;

    assign accept           = bus.rx_valid && rx_ready;
    assign bus.rx_ready     = rx_ready;
    assign bus.weights_en   = weights_en;
    assign bus.weights_data = weights_data;
    assign bus.load_done    = load_done;
    assign bus.load_error   = load_error;
    assign bus.busy         = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            sum          <= '0;
            for (int i = 0; i < WEIGHT_COUNT; i++) begin
                wbuf[i] <= '0;
            end
            rx_ready     <= 1'b1;
            weights_en   <= 1'b0;
            weights_data <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && bus.rx_data == SYNC_WORD) begin
                        state <= S_RECV;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        sum <= sum + bus.rx_data;
                        // The byte after the last weight is the checksum: summed, never stored.
                        if (cnt == LAST) begin
                            state    <= S_CHECK;
                            rx_ready <= 1'b0;
                        end else begin
                            wbuf[cnt] <= bus.rx_data;
                            cnt       <= cnt + ONE;
                        end
                    end
                end
                S_CHECK: begin
                    if (sum == '0) begin
                        state        <= S_REPLAY;
                        weights_en   <= 1'b1;
                        weights_data <= wbuf[0];
                        cnt          <= ONE;
                    end else begin
                        state      <= S_IDLE;
                        load_error <= 1'b1;
                        rx_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                S_REPLAY: begin
                    // cnt indexes the next word to present; LAST means the final word is on the bus now.
                    if (cnt == LAST) begin
                        state        <= S_IDLE;
                        weights_en   <= 1'b0;
                        weights_data <= '0;
                        load_done    <= 1'b1;
                        rx_ready     <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        weights_data <= wbuf[cnt];
                        cnt          <= cnt + ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nn_weight_loader.sv
// Bench for nn_weight_loader: frame table, hand-built timing sequences and random streams vs a frame-scanning model.
module tb_nn_weight_loader;
    localparam int W = 8;
    localparam int N = 9;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nn_weight_loader_if #(.BITS_PER_WORD(W)) bus();

    nn_weight_loader #(
        .BITS_PER_WORD(W),
        .WEIGHT_COUNT (N),
        .SYNC_WORD    (8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] b [14];
        int         len;
        int         done;
        int         err;
        logic [7:0] w [9];
    } vec_t;

    vec_t       vt [4];
    int         checks   = 0;
    int         passes   = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         burst    = 0;
    logic       prev_en  = 1'b0;
    int         exp_done;
    int         exp_err;
    logic [7:0] got_w [$];
    logic [7:0] acc   [$];
    logic [7:0] sent  [$];
    logic [7:0] exp_w [$];

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chk_w(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Output monitor: records transfers and delivered words, checks burst shape.
    always @(negedge clk) begin
        if (reset) begin
            burst   = 0;
            prev_en = 1'b0;
        end else begin
            if (bus.rx_valid && bus.rx_ready) acc.push_back(bus.rx_data);
            if (bus.load_done) done_cnt++;
            if (bus.load_error) err_cnt++;
            if (bus.weights_en) begin
                got_w.push_back(bus.weights_data);
                burst++;
                chk_b("ready_low_in_replay", bus.rx_ready, 1'b0);
            end else if (prev_en) begin
                chk_i("burst_len", burst, N);
                chk_b("done_after_burst", bus.load_done, 1'b1);
                burst = 0;
            end
            prev_en = bus.weights_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.rx_ready) chk_b("send_ready_timeout", bus.rx_ready, 1'b1);
        sent.push_back(b);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        if (bus.busy) chk_b("drain_timeout", bus.busy, 1'b0);
        tick();
        tick();
    endtask

    // Reference: scan the byte stream for sync words; each sync plus the next ten bytes is one frame.
    task automatic model();
        int         i = 0;
        logic [7:0] s;
        exp_w.delete();
        exp_done = 0;
        exp_err  = 0;
        while (i < sent.size()) begin
            if (sent[i] == 8'hA5 && i + 10 < sent.size()) begin
                s = 8'h00;
                for (int k = 1; k <= 10; k++) s = s + sent[i+k];
                if (s == 8'h00) begin
                    for (int k = 1; k <= 9; k++) exp_w.push_back(sent[i+k]);
                    exp_done++;
                end else begin
                    exp_err++;
                end
                i += 11;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        int         d0;
        int         e0;
        int         a0;
        logic [7:0] b;
        logic [7:0] sum;
        logic [7:0] ck;

        // Weights 00 FF 01 01 01 01 00 01 FE sum to 2, so the checksum is FE.
        vt[0].b = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00};
        vt[0].len = 11; vt[0].done = 1; vt[0].err = 0;
        vt[0].w = '{8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE};
        vt[1].b = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[1].len = 11; vt[1].done = 0; vt[1].err = 1;
        vt[1].w = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2].b = '{8'h12, 8'h34, 8'hFF, 8'hA5, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE, 8'hFE};
        vt[2].len = 14; vt[2].done = 1; vt[2].err = 0;
        vt[2].w = vt[0].w;
        vt[3].b = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5B, 8'h00, 8'h00, 8'h00};
        vt[3].len = 11; vt[3].done = 1; vt[3].err = 0;
        vt[3].w = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1 reset = 1'b1;
        #2;
        chk_b("reset_rx_ready", bus.rx_ready, 1'b1);
        chk_b("reset_weights_en", bus.weights_en, 1'b0);
        chk_w("reset_weights_data", bus.weights_data, 8'h00);
        chk_b("reset_load_done", bus.load_done, 1'b0);
        chk_b("reset_load_error", bus.load_error, 1'b0);
        chk_b("reset_busy", bus.busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            got_w.delete();
            d0 = done_cnt;
            e0 = err_cnt;
            for (int j = 0; j < vt[v].len; j++) send(vt[v].b[j]);
            drain();
            chk_i($sformatf("vec%0d_done", v), done_cnt - d0, vt[v].done);
            chk_i($sformatf("vec%0d_error", v), err_cnt - e0, vt[v].err);
            chk_i($sformatf("vec%0d_words", v), got_w.size(), vt[v].done * N);
            if (got_w.size() == vt[v].done * N && vt[v].done == 1)
                for (int k = 0; k < N; k++) chk_w($sformatf("vec%0d_w%0d", v, k), got_w[k], vt[v].w[k]);
        end

        // Stall mid-RECV, then hold the next sync valid through CHECK and REPLAY.
        got_w.delete();
        d0 = done_cnt;
        for (int j = 0; j < 6; j++) send(vt[0].b[j]);
        tick();
        tick();
        chk_b("stall_ready", bus.rx_ready, 1'b1);
        chk_b("stall_busy", bus.busy, 1'b1);
        for (int j = 6; j < 11; j++) send(vt[0].b[j]);
        chk_b("check_ready", bus.rx_ready, 1'b0);
        chk_b("check_en", bus.weights_en, 1'b0);
        chk_b("check_busy", bus.busy, 1'b1);
        a0 = acc.size();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_b($sformatf("lat_en_%0d", k), bus.weights_en, k <= 9);
            chk_b($sformatf("lat_ready_%0d", k), bus.rx_ready, k == 10);
            chk_b($sformatf("lat_done_%0d", k), bus.load_done, k == 10);
            chk_b($sformatf("lat_busy_%0d", k), bus.busy, k <= 9);
        end
        chk_i("no_consume_in_replay", acc.size(), a0);
        tick();
        bus.rx_valid = 1'b0;
        chk_b("b2b_sync_busy", bus.busy, 1'b1);
        for (int j = 1; j < 11; j++) send(vt[0].b[j]);
        drain();
        chk_i("b2b_done", done_cnt - d0, 2);
        chk_i("b2b_words", got_w.size(), 2 * N);
        if (got_w.size() == 2 * N)
            for (int k = 0; k < 2 * N; k++) chk_w($sformatf("b2b_w%0d", k), got_w[k], vt[0].w[k % N]);

        // Bad checksum, then a sync accepted in the load_error cycle.
        got_w.delete();
        e0 = err_cnt;
        for (int j = 0; j < 11; j++) send(vt[1].b[j]);
        chk_b("err_check_cycle", bus.load_error, 1'b0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        tick();
        chk_b("err_pulse", bus.load_error, 1'b1);
        chk_b("err_ready", bus.rx_ready, 1'b1);
        chk_b("err_busy", bus.busy, 1'b0);
        chk_b("err_no_en", bus.weights_en, 1'b0);
        tick();
        bus.rx_valid = 1'b0;
        chk_b("err_pulse_width", bus.load_error, 1'b0);
        chk_b("resync_busy", bus.busy, 1'b1);
        for (int j = 1; j < 11; j++) send(vt[0].b[j]);
        drain();
        chk_i("resync_error_count", err_cnt - e0, 1);
        chk_i("resync_words", got_w.size(), N);

        // Asynchronous reset while the 4th word is on the bus.
        got_w.delete();
        d0 = done_cnt;
        for (int j = 0; j < 11; j++) send(vt[0].b[j]);
        repeat (4) tick();
        chk_b("pre_reset_en", bus.weights_en, 1'b1);
        chk_w("pre_reset_word", bus.weights_data, vt[0].w[3]);
        #2 reset = 1'b1;
        #1;
        chk_b("async_rst_en", bus.weights_en, 1'b0);
        chk_b("async_rst_busy", bus.busy, 1'b0);
        chk_b("async_rst_ready", bus.rx_ready, 1'b1);
        chk_w("async_rst_data", bus.weights_data, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk_i("no_done_after_reset", done_cnt - d0, 0);
        got_w.delete();
        for (int j = 0; j < 11; j++) send(vt[0].b[j]);
        drain();
        chk_i("post_reset_words", got_w.size(), N);
        if (got_w.size() == N)
            for (int k = 0; k < N; k++) chk_w($sformatf("post_reset_w%0d", k), got_w[k], vt[0].w[k]);

        // Random frames with garbage, gaps and mostly-correct checksums.
        sent.delete();
        acc.delete();
        got_w.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int f = 0; f < 25; f++) begin
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h3C;
                send(b);
            end
            repeat ($urandom_range(0, 2)) tick();
            send(8'hA5);
            sum = 8'h00;
            for (int k = 0; k < N; k++) begin
                b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
                sum = sum + b;
                send(b);
                if ($urandom_range(0, 3) == 0) tick();
            end
            ck = ($urandom_range(0, 3) != 0) ? 8'(-sum) : 8'($urandom);
            send(ck);
        end
        drain();
        model();
        chk_i("rand_accepted", acc.size(), sent.size());
        chk_i("rand_done", done_cnt - d0, exp_done);
        chk_i("rand_error", err_cnt - e0, exp_err);
        chk_i("rand_words", got_w.size(), exp_w.size());
        if (got_w.size() == exp_w.size())
            for (int k = 0; k < exp_w.size(); k++) chk_w($sformatf("rand_w%0d", k), got_w[k], exp_w[k]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1);
    end
endmodule
